// File: rtl/ram8_dma_pkg.sv
// Shared types and constants for the ram8 block-transfer engine.
package ram8_dma_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AW    = 3;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram8_dma_ctr.sv
// Destination pointer (wraps modulo 2^AW) with a companion word down-counter.
module ram8_dma_ctr #(
    parameter int AW = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [AW-1:0] ptr_init_i,
    input  logic [AW:0]   cnt_init_i,
    output logic [AW-1:0] ptr_o,
    output logic          zero_next_o
);

    logic [AW-1:0] ptr_q;
    logic [AW:0]   cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            ptr_q <= ptr_init_i;
            cnt_q <= cnt_init_i;
        end else if (step_i) begin
            ptr_q <= ptr_q + AW'(1);
            cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    assign ptr_o = ptr_q;
    // Zero flag as seen after the pending step: lets the FSM leave WRITE on the last word.
    assign zero_next_o = (cnt_q == (AW+1)'(1));

endmodule

// File: rtl/ram8_dma.sv
// Autonomous COPY/FILL engine driving the ram8 port; outputs decode from registered state only.
module ram8_dma
    import ram8_dma_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [AW-1:0]    src,
    input  logic [AW-1:0]    dst,
    input  logic [AW:0]      len,
    input  logic [WIDTH-1:0] fill_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mem_in,
    output logic             mem_load,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_out
);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] fill_q, fill_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    src_q, src_d;
    logic [AW-1:0]    addr_q, addr_d;

    logic             ctr_load;
    logic             ctr_step;
    logic [AW-1:0]    dst_ptr;
    logic             cnt_last;

    ram8_dma_ctr #(.AW(AW)) u_ctr (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_i      (ctr_load),
        .step_i      (ctr_step),
        .ptr_init_i  (dst),
        .cnt_init_i  (len),
        .ptr_o       (dst_ptr),
        .zero_next_o (cnt_last)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_COPY;
            fill_q  <= '0;
            data_q  <= '0;
            src_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        fill_d   = fill_q;
        data_d   = data_q;
        src_d    = src_q;
        addr_d   = addr_q;
        ctr_load = 1'b0;
        ctr_step = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        mem_load = 1'b0;
        mem_in   = '0;
        mem_addr = addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    fill_d   = fill_val;
                    src_d    = src;
                    ctr_load = 1'b1;
                    if (len == '0)
                        state_d = ST_DONE;
                    else if (mode == MODE_FILL)
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ: begin
                busy     = 1'b1;
                mem_addr = src_q;
                addr_d   = src_q;
                data_d   = mem_out;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                busy     = 1'b1;
                mem_addr = dst_ptr;
                addr_d   = dst_ptr;
                mem_load = 1'b1;
                mem_in   = (mode_q == MODE_FILL) ? fill_q : data_q;
                ctr_step = 1'b1;
                src_d    = src_q + AW'(1);
                if (cnt_last)
                    state_d = ST_DONE;
                else if (mode_q == MODE_COPY)
                    state_d = ST_READ;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
